// File: rtl/cci_mpf_shim_tx_sched_pkg.sv
// Shared types and helpers for the two-source CCI Tx scheduler.
// Statistics counters are built only when CCI_MPF_TX_SCHED_STATS_EN is defined.
package cci_mpf_shim_tx_sched_pkg;

    typedef logic [0:0] t_sched_src;
    typedef logic [3:0] t_sched_run;

    localparam int BURST_MAX = 15;

    // Source 0 wins the first contention after reset.
    localparam t_sched_src SRC_RESET_LAST = 1'b1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        logic [31:0] r;
        if (v == 32'hFFFF_FFFF) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

    function automatic logic [1:0] src_onehot(input t_sched_src s);
        logic [1:0] r;
        if (s == 1'b1) begin
            r = 2'b10;
        end else begin
            r = 2'b01;
        end
        return r;
    endfunction

endpackage

// File: rtl/cci_mpf_shim_tx_sched_arb.sv
// Burst-limited round-robin arbiter between two sources for one CCI Tx channel.
// Grant is combinational. The last winner and run length are registered.
module cci_mpf_shim_tx_sched_arb
    import cci_mpf_shim_tx_sched_pkg::*;
#(
    parameter int BURST = 4
)
(
    input  logic       clk,
    input  logic       resetb,
    input  logic [1:0] req,
    input  logic       block,
    output logic [1:0] grant
);

    localparam t_sched_run BURST_RUN = t_sched_run'(BURST);

    t_sched_src last_r;
    t_sched_run run_r;
    t_sched_src gsrc_s;
    logic       gvalid_s;

    // Choose the winning source for this cycle.
    always_comb begin
        gvalid_s = 1'b0;
        gsrc_s   = last_r;
        if (block) begin
            gvalid_s = 1'b0;
            gsrc_s   = last_r;
        end else begin
            case (req)
                2'b01: begin
                    gvalid_s = 1'b1;
                    gsrc_s   = 1'b0;
                end
                2'b10: begin
                    gvalid_s = 1'b1;
                    gsrc_s   = 1'b1;
                end
                2'b11: begin
                    gvalid_s = 1'b1;
                    // run==0 exists only after reset, so it hands the first contention to !last.
                    if ((run_r == 4'd0) || (run_r >= BURST_RUN)) begin
                        gsrc_s = ~last_r;
                    end else begin
                        gsrc_s = last_r;
                    end
                end
                default: begin
                    gvalid_s = 1'b0;
                    gsrc_s   = last_r;
                end
            endcase
        end
    end

    // Expand the winner to a one-hot grant.
    always_comb begin
        grant = 2'b00;
        if (gvalid_s) begin
            grant = src_onehot(gsrc_s);
        end else begin
            grant = 2'b00;
        end
    end

    // Track the last winner and its consecutive grant count. Idle cycles hold the state.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            last_r <= SRC_RESET_LAST;
            run_r  <= 4'd0;
        end else if (gvalid_s) begin
            if (gsrc_s == last_r) begin
                if (run_r < BURST_RUN) begin
                    run_r <= run_r + 4'd1;
                end else begin
                    run_r <= BURST_RUN;
                end
            end else begin
                last_r <= gsrc_s;
                run_r  <= 4'd1;
            end
        end else begin
            last_r <= last_r;
            run_r  <= run_r;
        end
    end

endmodule

// File: rtl/cci_mpf_shim_tx_sched.sv
// Shares one QLP-side CCI Tx port between two buffered AFU request streams.
// Define CCI_MPF_TX_SCHED_STATS_EN to add per-source grant counters.
module cci_mpf_shim_tx_sched
    import cci_mpf_shim_tx_sched_pkg::*;
#(
    parameter int CCI_DATA_WIDTH   = 512,
    parameter int CCI_TX_HDR_WIDTH = 61,
    parameter int BURST            = 4
)
(
    input  logic                        clk,
    input  logic                        resetb,

    input  logic [1:0]                  s_c0_valid,
    input  logic [CCI_TX_HDR_WIDTH-1:0] s_c0_hdr [2],
    output logic [1:0]                  s_c0_deq,

    input  logic [1:0]                  s_c1_wr_valid,
    input  logic [1:0]                  s_c1_ir_valid,
    input  logic [CCI_TX_HDR_WIDTH-1:0] s_c1_hdr [2],
    input  logic [CCI_DATA_WIDTH-1:0]   s_c1_data [2],
    output logic [1:0]                  s_c1_deq,

    input  logic                        q_c0_almfull,
    input  logic                        q_c1_almfull,

    output logic                        q_c0_rd_valid,
    output logic [CCI_TX_HDR_WIDTH-1:0] q_c0_hdr,
    output logic                        q_c1_wr_valid,
    output logic                        q_c1_ir_valid,
    output logic [CCI_TX_HDR_WIDTH-1:0] q_c1_hdr,
    output logic [CCI_DATA_WIDTH-1:0]   q_c1_data
`ifdef CCI_MPF_TX_SCHED_STATS_EN
    ,
    output logic [31:0]                 stat_c0_grants [2],
    output logic [31:0]                 stat_c1_grants [2]
`endif
);

    logic [1:0] c0_grant_s;
    logic [1:0] c1_grant_s;
    logic [1:0] c1_req_s;
    t_sched_src c0_src_s;
    t_sched_src c1_src_s;

    assign c1_req_s = s_c1_wr_valid | s_c1_ir_valid;
    assign c0_src_s = c0_grant_s[1];
    assign c1_src_s = c1_grant_s[1];

    cci_mpf_shim_tx_sched_arb #(
        .BURST (BURST)
    ) arb_c0 (
        .clk    (clk),
        .resetb (resetb),
        .req    (s_c0_valid),
        .block  (q_c0_almfull),
        .grant  (c0_grant_s)
    );

    cci_mpf_shim_tx_sched_arb #(
        .BURST (BURST)
    ) arb_c1 (
        .clk    (clk),
        .resetb (resetb),
        .req    (c1_req_s),
        .block  (q_c1_almfull),
        .grant  (c1_grant_s)
    );

    // Dequeue the granted heads. No dequeue is issued while reset is held.
    always_comb begin
        s_c0_deq = 2'b00;
        s_c1_deq = 2'b00;
        if (resetb) begin
            s_c0_deq = c0_grant_s;
            s_c1_deq = c1_grant_s;
        end else begin
            s_c0_deq = 2'b00;
            s_c1_deq = 2'b00;
        end
    end

    // C0 output register toward the QLP.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            q_c0_rd_valid <= 1'b0;
            q_c0_hdr      <= {CCI_TX_HDR_WIDTH{1'b0}};
        end else if (|c0_grant_s) begin
            q_c0_rd_valid <= 1'b1;
            q_c0_hdr      <= s_c0_hdr[c0_src_s];
        end else begin
            q_c0_rd_valid <= 1'b0;
            q_c0_hdr      <= q_c0_hdr;
        end
    end

    // C1 output register. Both valid bits travel with the payload.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            q_c1_wr_valid <= 1'b0;
            q_c1_ir_valid <= 1'b0;
            q_c1_hdr      <= {CCI_TX_HDR_WIDTH{1'b0}};
            q_c1_data     <= {CCI_DATA_WIDTH{1'b0}};
        end else if (|c1_grant_s) begin
            q_c1_wr_valid <= s_c1_wr_valid[c1_src_s];
            q_c1_ir_valid <= s_c1_ir_valid[c1_src_s];
            q_c1_hdr      <= s_c1_hdr[c1_src_s];
            q_c1_data     <= s_c1_data[c1_src_s];
        end else begin
            q_c1_wr_valid <= 1'b0;
            q_c1_ir_valid <= 1'b0;
            q_c1_hdr      <= q_c1_hdr;
            q_c1_data     <= q_c1_data;
        end
    end

`ifdef CCI_MPF_TX_SCHED_STATS_EN
    // Saturating per-source grant counters.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int s = 0; s < 2; s++) begin
                stat_c0_grants[s] <= 32'd0;
                stat_c1_grants[s] <= 32'd0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (c0_grant_s[s]) begin
                    stat_c0_grants[s] <= sat_inc32(stat_c0_grants[s]);
                end else begin
                    stat_c0_grants[s] <= stat_c0_grants[s];
                end
                if (c1_grant_s[s]) begin
                    stat_c1_grants[s] <= sat_inc32(stat_c1_grants[s]);
                end else begin
                    stat_c1_grants[s] <= stat_c1_grants[s];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cci_mpf_shim_tx_sched.sv
// Directed self-checking bench for cci_mpf_shim_tx_sched (BURST=4).
module tb_cci_mpf_shim_tx_sched;

    localparam int HW = 61;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          resetb;
    logic [1:0]    s_c0_valid;
    logic [HW-1:0] s_c0_hdr [2];
    logic [1:0]    s_c0_deq;
    logic [1:0]    s_c1_wr_valid;
    logic [1:0]    s_c1_ir_valid;
    logic [HW-1:0] s_c1_hdr [2];
    logic [DW-1:0] s_c1_data [2];
    logic [1:0]    s_c1_deq;
    logic          q_c0_almfull;
    logic          q_c1_almfull;
    logic          q_c0_rd_valid;
    logic [HW-1:0] q_c0_hdr;
    logic          q_c1_wr_valid;
    logic          q_c1_ir_valid;
    logic [HW-1:0] q_c1_hdr;
    logic [DW-1:0] q_c1_data;
`ifdef CCI_MPF_TX_SCHED_STATS_EN
    logic [31:0]   stat_c0_grants [2];
    logic [31:0]   stat_c1_grants [2];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cci_mpf_shim_tx_sched #(
        .CCI_DATA_WIDTH   (DW),
        .CCI_TX_HDR_WIDTH (HW),
        .BURST            (4)
    ) dut (
        .clk           (clk),
        .resetb        (resetb),
        .s_c0_valid    (s_c0_valid),
        .s_c0_hdr      (s_c0_hdr),
        .s_c0_deq      (s_c0_deq),
        .s_c1_wr_valid (s_c1_wr_valid),
        .s_c1_ir_valid (s_c1_ir_valid),
        .s_c1_hdr      (s_c1_hdr),
        .s_c1_data     (s_c1_data),
        .s_c1_deq      (s_c1_deq),
        .q_c0_almfull  (q_c0_almfull),
        .q_c1_almfull  (q_c1_almfull),
        .q_c0_rd_valid (q_c0_rd_valid),
        .q_c0_hdr      (q_c0_hdr),
        .q_c1_wr_valid (q_c1_wr_valid),
        .q_c1_ir_valid (q_c1_ir_valid),
        .q_c1_hdr      (q_c1_hdr),
        .q_c1_data     (q_c1_data)
`ifdef CCI_MPF_TX_SCHED_STATS_EN
        ,
        .stat_c0_grants (stat_c0_grants),
        .stat_c1_grants (stat_c1_grants)
`endif
    );

    task automatic clear_inputs();
        s_c0_valid    = 2'b00;
        s_c1_wr_valid = 2'b00;
        s_c1_ir_valid = 2'b00;
        q_c0_almfull  = 1'b0;
        q_c1_almfull  = 1'b0;
        for (int s = 0; s < 2; s++) begin
            s_c0_hdr[s]  = '0;
            s_c1_hdr[s]  = '0;
            s_c1_data[s] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetb = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        resetb = 1'b1;
    endtask

    // Drive C0 heads at the negedge; hdr[s] = tag*2+s.
    task automatic set_c0(input logic [1:0] v, input logic af, input int tag);
        @(negedge clk);
        s_c0_valid   = v;
        q_c0_almfull = af;
        s_c0_hdr[0]  = HW'(tag * 2);
        s_c0_hdr[1]  = HW'(tag * 2 + 1);
        #1;
    endtask

    // Drive C1 heads at the negedge; hdr[s] = 0x1000+tag*2+s, data replicates it.
    task automatic set_c1(input logic [1:0] wr, input logic [1:0] ir, input logic af, input int tag);
        @(negedge clk);
        s_c1_wr_valid = wr;
        s_c1_ir_valid = ir;
        q_c1_almfull  = af;
        for (int s = 0; s < 2; s++) begin
            s_c1_hdr[s]  = HW'(32'h1000 + tag * 2 + s);
            s_c1_data[s] = {16{32'(32'h1000 + tag * 2 + s)}};
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        tick();
        total++;
        if (q_c0_rd_valid !== 1'b0 || q_c1_wr_valid !== 1'b0 || q_c1_ir_valid !== 1'b0) begin
            $display("FAIL reset_valids got=%b%b%b exp=000", q_c0_rd_valid, q_c1_wr_valid, q_c1_ir_valid);
            bad++;
        end
        total++;
        if (s_c0_deq !== 2'b00 || s_c1_deq !== 2'b00) begin
            $display("FAIL reset_deq got=%b/%b exp=00/00", s_c0_deq, s_c1_deq);
            bad++;
        end
        total++;
        if (q_c0_hdr !== '0 || q_c1_hdr !== '0 || q_c1_data !== '0) begin
            $display("FAIL reset_payload got c0hdr=%h c1hdr=%h exp=0", q_c0_hdr, q_c1_hdr);
            bad++;
        end
        set_c0(2'b11, 1'b0, 100);
        total++;
        if (s_c0_deq !== 2'b01) begin
            $display("FAIL reset_first_deq got=%b exp=01", s_c0_deq);
            bad++;
        end
        tick();
        total++;
        if (q_c0_rd_valid !== 1'b1 || q_c0_hdr !== HW'(200)) begin
            $display("FAIL reset_first_req got v=%b hdr=%0d exp v=1 hdr=200", q_c0_rd_valid, q_c0_hdr);
            bad++;
        end
    endtask

    task automatic test_burst();
        int exp_src;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            exp_src = (i / 4) % 2;
            set_c0(2'b11, 1'b0, i);
            total++;
            if (s_c0_deq !== 2'(1 << exp_src)) begin
                $display("FAIL burst_deq[%0d] got=%b exp=%b", i, s_c0_deq, 2'(1 << exp_src));
                bad++;
            end
            tick();
            total++;
            if (q_c0_rd_valid !== 1'b1 || q_c0_hdr !== HW'(i * 2 + exp_src)) begin
                $display("FAIL burst_req[%0d] got v=%b hdr=%0d exp v=1 hdr=%0d", i, q_c0_rd_valid, q_c0_hdr, i * 2 + exp_src);
                bad++;
            end
        end
`ifdef CCI_MPF_TX_SCHED_STATS_EN
        total++;
        if (stat_c0_grants[0] !== 32'd8 || stat_c0_grants[1] !== 32'd4) begin
            $display("FAIL burst_stats got=%0d/%0d exp=8/4", stat_c0_grants[0], stat_c0_grants[1]);
            bad++;
        end
`endif
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_c0(2'b10, 1'b0, 20 + i);
            total++;
            if (s_c0_deq !== 2'b10) begin
                $display("FAIL single_deq[%0d] got=%b exp=10", i, s_c0_deq);
                bad++;
            end
            tick();
            total++;
            if (q_c0_rd_valid !== 1'b1 || q_c0_hdr !== HW'((20 + i) * 2 + 1)) begin
                $display("FAIL single_req[%0d] got v=%b hdr=%0d exp v=1 hdr=%0d", i, q_c0_rd_valid, q_c0_hdr, (20 + i) * 2 + 1);
                bad++;
            end
        end
        set_c0(2'b11, 1'b0, 40);
        total++;
        if (s_c0_deq !== 2'b01) begin
            $display("FAIL single_switch_deq got=%b exp=01", s_c0_deq);
            bad++;
        end
        tick();
        total++;
        if (q_c0_hdr !== HW'(80)) begin
            $display("FAIL single_switch_hdr got=%0d exp=80", q_c0_hdr);
            bad++;
        end
    endtask

    task automatic test_almfull();
        logic [1:0] ed [10];
        logic       af;
        ed = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            af = (i >= 5 && i <= 7) ? 1'b1 : 1'b0;
            set_c1(2'b11, 2'b00, af, i);
            total++;
            if (s_c1_deq !== ed[i]) begin
                $display("FAIL almfull_deq[%0d] got=%b exp=%b", i, s_c1_deq, ed[i]);
                bad++;
            end
            tick();
            total++;
            if (q_c1_wr_valid !== (|ed[i])) begin
                $display("FAIL almfull_valid[%0d] got=%b exp=%b", i, q_c1_wr_valid, |ed[i]);
                bad++;
            end
            if (|ed[i]) begin
                total++;
                if (q_c1_hdr !== HW'(32'h1000 + i * 2 + ed[i][1])) begin
                    $display("FAIL almfull_hdr[%0d] got=%h exp=%h", i, q_c1_hdr, 32'h1000 + i * 2 + ed[i][1]);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_payload();
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        d0 = {64{8'hA5}};
        d1 = {16{32'h0123_4567}};
        do_reset();
        @(negedge clk);
        s_c0_valid    = 2'b11;
        s_c0_hdr[0]   = HW'(500);
        s_c0_hdr[1]   = HW'(501);
        s_c1_wr_valid = 2'b01;
        s_c1_ir_valid = 2'b10;
        s_c1_hdr[0]   = HW'(61'h0AAA_0000_1234);
        s_c1_hdr[1]   = HW'(61'h1555_0000_4321);
        s_c1_data[0]  = d0;
        s_c1_data[1]  = d1;
        #1;
        total++;
        if (s_c1_deq !== 2'b01 || s_c0_deq !== 2'b01) begin
            $display("FAIL payload_deq0 got c1=%b c0=%b exp 01/01", s_c1_deq, s_c0_deq);
            bad++;
        end
        tick();
        total++;
        if (q_c1_wr_valid !== 1'b1 || q_c1_ir_valid !== 1'b0 || q_c1_hdr !== HW'(61'h0AAA_0000_1234) || q_c1_data !== d0) begin
            $display("FAIL payload_wr got wr=%b ir=%b hdr=%h exp wr=1 ir=0 hdr=0aaa00001234 data=a5", q_c1_wr_valid, q_c1_ir_valid, q_c1_hdr);
            bad++;
        end
        total++;
        if (q_c0_rd_valid !== 1'b1 || q_c0_hdr !== HW'(500)) begin
            $display("FAIL payload_c0_a got v=%b hdr=%0d exp v=1 hdr=500", q_c0_rd_valid, q_c0_hdr);
            bad++;
        end
        @(negedge clk);
        s_c1_wr_valid = 2'b00;
        s_c0_hdr[0]   = HW'(502);
        #1;
        total++;
        if (s_c1_deq !== 2'b10) begin
            $display("FAIL payload_deq1 got=%b exp=10", s_c1_deq);
            bad++;
        end
        tick();
        total++;
        if (q_c1_wr_valid !== 1'b0 || q_c1_ir_valid !== 1'b1 || q_c1_hdr !== HW'(61'h1555_0000_4321) || q_c1_data !== d1) begin
            $display("FAIL payload_ir got wr=%b ir=%b hdr=%h exp wr=0 ir=1 hdr=155500004321", q_c1_wr_valid, q_c1_ir_valid, q_c1_hdr);
            bad++;
        end
        total++;
        if (q_c0_rd_valid !== 1'b1 || q_c0_hdr !== HW'(502)) begin
            $display("FAIL payload_c0_b got v=%b hdr=%0d exp v=1 hdr=502", q_c0_rd_valid, q_c0_hdr);
            bad++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        // Four grants to 0 then one to 1 leaves last=1 run=1, which would favour 1 without a reset.
        for (int i = 0; i < 5; i++) begin
            set_c0(2'b11, 1'b0, 60 + i);
            tick();
        end
        total++;
        if (q_c0_rd_valid !== 1'b1) begin
            $display("FAIL midrst_pre got=%b exp=1", q_c0_rd_valid);
            bad++;
        end
        #1 resetb = 1'b0;
        #1;
        total++;
        if (q_c0_rd_valid !== 1'b0) begin
            $display("FAIL midrst_async got=%b exp=0", q_c0_rd_valid);
            bad++;
        end
        @(negedge clk);
        resetb = 1'b1;
        set_c0(2'b11, 1'b0, 70);
        total++;
        if (s_c0_deq !== 2'b01) begin
            $display("FAIL midrst_first_deq got=%b exp=01", s_c0_deq);
            bad++;
        end
`ifdef CCI_MPF_TX_SCHED_STATS_EN
        total++;
        if (stat_c0_grants[0] !== 32'd0 || stat_c0_grants[1] !== 32'd0 ||
            stat_c1_grants[0] !== 32'd0 || stat_c1_grants[1] !== 32'd0) begin
            $display("FAIL midrst_stats got=%0d/%0d/%0d/%0d exp=0", stat_c0_grants[0], stat_c0_grants[1], stat_c1_grants[0], stat_c1_grants[1]);
            bad++;
        end
`endif
        tick();
        total++;
        if (q_c0_rd_valid !== 1'b1 || q_c0_hdr !== HW'(140)) begin
            $display("FAIL midrst_first_req got v=%b hdr=%0d exp v=1 hdr=140", q_c0_rd_valid, q_c0_hdr);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_single();
        test_almfull();
        test_payload();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cci_mpf_shim_tx_sched.md
# cci_mpf_shim_tx_sched

Two-source Tx scheduler that shares one QLP-side CCI Tx port between two buffered AFU request streams, each produced by a buffer shim that exposes FIFO heads and accepts explicit dequeues. Per channel it picks a source with a burst-limited round-robin policy and honours the QLP almost-full signal. It drives that source's deqC0Tx/deqC1Tx and forwards the request through a one-stage output register. It sits between two buffer shims and the next shim (or QLP) toward the platform.

## Interface
Parameters:
- CCI_DATA_WIDTH, 512, store data width
- CCI_TX_HDR_WIDTH, 61, Tx header width
- BURST, 4, max consecutive grants to one source while the other waits (1..15)

Ports:
- clk  in  1  sole clock
- resetb  in  1  asynchronous, active-low reset
- s_c0_valid[1:0]  in  2  per-source C0 FIFO head valid (C0TxRdValid)
- s_c0_hdr[s]  in  CCI_TX_HDR_WIDTH  per-source C0 head header
- s_c0_deq[1:0]  out  2  per-source deqC0Tx
- s_c1_wr_valid[1:0], s_c1_ir_valid[1:0]  in  2 each  per-source C1 head valid bits
- s_c1_hdr[s]  in  CCI_TX_HDR_WIDTH; s_c1_data[s]  in  CCI_DATA_WIDTH  per-source C1 head
- s_c1_deq[1:0]  out  2  per-source deqC1Tx
- q_c0_almfull, q_c1_almfull  in  1 each  QLP C0TxAlmFull/C1TxAlmFull
- q_c0_rd_valid  out  1; q_c0_hdr  out  CCI_TX_HDR_WIDTH
- q_c1_wr_valid, q_c1_ir_valid  out  1 each; q_c1_hdr  out  CCI_TX_HDR_WIDTH; q_c1_data  out  CCI_DATA_WIDTH

## Operation
- C0 and C1 are scheduled independently, with identical arbiters. Source s requests C1 when s_c1_wr_valid[s] | s_c1_ir_valid[s].
- Issue allowed in cycle t iff q_cX_almfull==0 in t. At most one grant per channel per cycle.
- Arbiter state per channel: last (1 bit, last granted source) and run (4 bits, consecutive grants to last).
- Grant rule:
  - Only one source requests: grant it.
  - Both request and run < BURST: grant last.
  - Both request and run == BURST: grant !last.
- On a grant to g: if g==last, run <= run+1, saturating at BURST; otherwise run <= 1 and last <= g.
- No grant (no requests or almfull): state holds. An idle cycle does not reset run.
- s_cX_deq[g] is asserted combinationally in the grant cycle, one-hot or zero. It is never asserted for a source whose valid is low.
- Granted payload (hdr, data, both C1 valid bits) is registered into the q_* outputs.
- Reset values: all q_* valids 0, hdr/data 0, last 1 (so source 0 wins first contention), run 0, deq outputs 0.
- Reset asserted mid-operation clears the q_* valids and arbiter state immediately. No request in the output register is issued. Source FIFOs are reset by the same resetb.

## Timing
- Latency: deq in cycle t, request on q_* in cycle t+1, valid for exactly one cycle.
- Throughput: one request per channel per cycle while not almost-full.
- almfull is sampled in the grant cycle. At most one request is already in the output register when almfull rises, which is within the CCI 4-slot allowance.
- Deq outputs depend combinationally on source valids and almfull. The output register breaks the path toward the QLP.

## Configuration
- CCI_MPF_TX_SCHED_STATS_EN defined: adds outputs stat_c0_grants[s] and stat_c1_grants[s], 32 bits each, counting grants per source per channel. The counters saturate at 2^32-1 and reset to 0.
- Macro undefined: no counters and no stat ports; the scheduling behaviour is identical.

## Structure
- Shared package cci_mpf_shim_tx_sched_pkg:
  - t_sched_src (1-bit source id)
  - t_sched_run (4-bit run counter)
  - BURST_MAX = 15
- Sub-module cci_mpf_shim_tx_sched_arb:
  - Holds last/run state and the grant logic.
  - Inputs: req[1:0], block.
  - Outputs: grant one-hot.
  - Instantiated once per channel.

## Test plan
- Reset: hold resetb=0, then release with no requests -> all q_* valids 0, deq 0. With both C0 sources valid, cycle 1 grants source 0 and q_c0_hdr equals s_c0_hdr[0] one cycle later.
- Contention burst, BURST=4, both C0 sources continuously valid -> grant pattern 0,0,0,0,1,1,1,1,0,... with one q_c0_rd_valid every cycle.
- Single requester: only source 1 valid for 10 cycles -> 10 consecutive grants to source 1 and no forced switch. Then source 0 valid with run==4 -> source 0 granted next cycle.
- Almost-full: raise q_c1_almfull at cycle 5 with sources busy -> no s_c1_deq from cycle 5. At most one q_c1 valid in cycle 5 (from the cycle-4 grant), none afterwards. Deassert almfull -> issue resumes next cycle with arbiter state preserved.
- C1 payload integrity: source 1 issues an ir_valid-only request, source 0 a wr_valid request with data 0xA5 pattern -> each output carries the matching hdr/data/valid bits unaltered; C0 traffic continues uninterrupted in parallel.
- Mid-operation reset: assert resetb=0 while q_c0_rd_valid=1 -> q_c0_rd_valid drops without waiting for a clock edge. After release, source 0 wins first contention. With CCI_MPF_TX_SCHED_STATS_EN defined, all stat counters read 0.
